// File: rtl/interleaver_pkg.sv
// -----------------------------------------------------------------------------
// interleaver_pkg
// Shared types and helpers for the ping-pong row/column interleaver controller.
//   bank_state_t : per-bank occupancy (EMPTY / FULL)
//   wr_state_t   : write-side sequencer state (FILL / PAD)
//   DEF_ROWS/COLS: default block geometry
//   perm_addr()  : transposed read address for a given read count
// -----------------------------------------------------------------------------
package interleaver_pkg;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    typedef enum logic {
        W_FILL = 1'b0,
        W_PAD  = 1'b1
    } wr_state_t;

    localparam int unsigned DEF_ROWS = 4;
    localparam int unsigned DEF_COLS = 4;

    // Bits are written row-major; reading walks down each column first.
    // With power-of-two geometry the mod/div reduce to bit slicing.
    function automatic int unsigned perm_addr(input int unsigned rcnt,
                                              input int unsigned rows,
                                              input int unsigned cols);
        return (rcnt % rows) * cols + (rcnt / rows);
    endfunction

endpackage

// File: rtl/interleaver_bank_state.sv
// -----------------------------------------------------------------------------
// interleaver_bank_state
// Occupancy tracker for one interleaver memory bank.
//   clk       in  system clock
//   rst       in  asynchronous active-low reset
//   set_full  in  write side completed this bank (honoured only when EMPTY)
//   set_last  in  frame-end flag captured together with set_full
//   clr_full  in  read side drained this bank (honoured only when FULL)
//   full      out bank holds a complete block
//   last_flag out the block in this bank closes a frame
// -----------------------------------------------------------------------------
// state      | meaning
// -----------+-----------------------------------------------
// BANK_EMPTY | bank free, may be filled by the write side
// BANK_FULL  | complete block stored, waiting to be drained
// -----------------------------------------------------------------------------
module interleaver_bank_state
    import interleaver_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic set_full,
    input  logic set_last,
    input  logic clr_full,
    output logic full,
    output logic last_flag
);

    bank_state_t state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= BANK_EMPTY;
            last_flag <= 1'b0;
        end else begin
            case (state)
                BANK_EMPTY: begin
                    if (set_full) begin
                        state     <= BANK_FULL;
                        last_flag <= set_last;
                    end
                end
                BANK_FULL: begin
                    if (clr_full) begin
                        state     <= BANK_EMPTY;
                        last_flag <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign full = (state == BANK_FULL);

endmodule

// File: rtl/interleaver_ctrl.sv
// -----------------------------------------------------------------------------
// interleaver_ctrl
// Address/bank sequencer for a ping-pong row/column bit interleaver. Bits are
// accepted serially and written row-major into one bank while the other bank
// is read back column-major. A frame ending mid-block is padded with zeros.
//   clk        in  system clock, rising edge
//   rst        in  asynchronous active-low reset
//   in_valid   in  upstream bit valid
//   in_last    in  final bit of the frame (qualified by in_valid)
//   in_ready   out controller accepts a bit this cycle
//   wr_en      out write strobe to bank wr_bank
//   wr_pad     out write a zero instead of the input bit
//   wr_bank    out bank being filled
//   wr_addr    out linear write address
//   rd_bank    out bank being drained
//   rd_addr    out transposed read address (datapath reads combinationally)
//   out_valid  out output bit presented
//   out_ready  in  downstream accepts the output bit
//   out_last   out last output bit of the frame
//   busy       out a bank is FULL or padding is in progress
// -----------------------------------------------------------------------------
// state  | meaning
// -------+-----------------------------------------------------------
// W_FILL | accepting input bits into wr_bank while that bank is EMPTY
// W_PAD  | frame ended early; writing zeros up to the end of the block
// -----------------------------------------------------------------------------
module interleaver_ctrl
    import interleaver_pkg::*;
#(
    parameter  int unsigned ROWS = DEF_ROWS,
    parameter  int unsigned COLS = DEF_COLS,
    localparam int unsigned N    = ROWS * COLS,
    localparam int unsigned AW   = $clog2(N)
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic          wr_en,
    output logic          wr_pad,
    output logic          wr_bank,
    output logic [AW-1:0] wr_addr,
    output logic          rd_bank,
    output logic [AW-1:0] rd_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    wr_state_t     wstate;
    logic [AW-1:0] wcnt;
    logic [AW-1:0] rcnt;
    logic          run;

    logic [1:0]    bank_full;
    logic [1:0]    bank_last;
    logic [1:0]    set_full;
    logic [1:0]    clr_full;
    logic          set_last;

    logic          accept;
    logic          wr_done;
    logic          rd_hs;
    logic          rd_done;

    // Write side ------------------------------------------------------------
    // run keeps in_ready low while reset is held and for the first edge after.
    assign in_ready = run & (wstate == W_FILL) & ~bank_full[wr_bank];
    assign accept   = in_valid & in_ready;
    assign wr_pad   = (wstate == W_PAD);
    assign wr_en    = accept | wr_pad;
    assign wr_addr  = wcnt;
    assign wr_done  = wr_en & (wcnt == LAST_ADDR);
    // A padded block always ends a frame; a full block ends one only if the
    // final bit carried in_last.
    assign set_last = wr_pad | in_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wstate  <= W_FILL;
            wcnt    <= '0;
            wr_bank <= 1'b0;
            run     <= 1'b0;
        end else begin
            run <= 1'b1;
            case (wstate)
                W_FILL: begin
                    if (accept) begin
                        if (wcnt == LAST_ADDR) begin
                            wcnt    <= '0;
                            wr_bank <= ~wr_bank;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                            if (in_last) begin
                                wstate <= W_PAD;
                            end
                        end
                    end
                end
                W_PAD: begin
                    if (wcnt == LAST_ADDR) begin
                        wcnt    <= '0;
                        wr_bank <= ~wr_bank;
                        wstate  <= W_FILL;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Read side -------------------------------------------------------------
    assign out_valid = bank_full[rd_bank];
    assign rd_hs     = out_valid & out_ready;
    assign rd_done   = rd_hs & (rcnt == LAST_ADDR);
    assign out_last  = out_valid & bank_last[rd_bank] & (rcnt == LAST_ADDR);
    assign rd_addr   = AW'(perm_addr(32'(rcnt), ROWS, COLS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt    <= '0;
            rd_bank <= 1'b0;
        end else if (rd_hs) begin
            if (rcnt == LAST_ADDR) begin
                rcnt    <= '0;
                rd_bank <= ~rd_bank;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
        end
    end

    // Bank occupancy ----------------------------------------------------------
    // The bank being filled is always EMPTY and the bank being drained always
    // FULL, so a completing write and a completing read never hit the same bank.
    always_comb begin
        set_full          = '0;
        clr_full          = '0;
        set_full[wr_bank] = wr_done;
        clr_full[rd_bank] = rd_done;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        interleaver_bank_state u_bank (
            .clk       (clk),
            .rst       (rst),
            .set_full  (set_full[b]),
            .set_last  (set_last),
            .clr_full  (clr_full[b]),
            .full      (bank_full[b]),
            .last_flag (bank_last[b])
        );
    end

    assign busy = (|bank_full) | wr_pad;

endmodule

// File: tb/tb_interleaver_ctrl.sv
// -----------------------------------------------------------------------------
// tb_interleaver_ctrl
// Self-checking bench: emulates the two block memories from wr_* strobes, reads
// them back through rd_* and compares against a frame-level model that pads
// each frame to whole blocks and transposes each block.
// -----------------------------------------------------------------------------
module tb_interleaver_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int N    = ROWS * COLS;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          wr_en;
    logic          wr_pad;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic          rd_bank;
    logic [AW-1:0] rd_addr;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    bit            in_bit = 1'b0;

    interleaver_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_pad    (wr_pad),
        .wr_bank   (wr_bank),
        .wr_addr   (wr_addr),
        .rd_bank   (rd_bank),
        .rd_addr   (rd_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit b;
        bit last;
    } obit_t;

    typedef struct {
        int len;
        bit gaps;
        int pct;
        int exp_pad;
        int exp_outs;
    } vec_t;

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    bit    mon_en = 1'b0;

    obit_t exp_q[$];
    bit    blk[$];
    int    perm_tab[N];
    bit    mem[2][N];

    int    w_pos, w_bank, r_pos, r_bank;
    bit    pad_exp;
    int    pad_cnt, out_cnt, last_cnt, ov_cnt, acc_cnt;
    int    first_acc, first_ov, last_ov;
    int    ordy_pct = 100;
    int    stall_left = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: collect bits into a block, zero-fill on frame end,
    // then queue the block in column-major order.
    function automatic void model_push(input bit b, input bit last);
        blk.push_back(b);
        if (blk.size() == N || last) begin
            while (blk.size() < N) blk.push_back(1'b0);
            for (int k = 0; k < N; k++) begin
                obit_t o;
                o.b    = blk[perm_tab[k]];
                o.last = last && (k == N - 1);
                exp_q.push_back(o);
            end
            blk.delete();
        end
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        blk.delete();
        w_pos = 0; w_bank = 0; r_pos = 0; r_bank = 0; pad_exp = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < N; a++) mem[b][a] = 1'b0;
    endfunction

    function automatic void clear_stats();
        pad_cnt = 0; out_cnt = 0; last_cnt = 0; ov_cnt = 0; acc_cnt = 0;
        first_acc = -1; first_ov = -1; last_ov = -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = (int'($urandom_range(99)) < ordy_pct);
        end
    endtask

    task automatic send_bit(input bit b, input bit last, input bit gaps);
        int n = 0;
        if (gaps && $urandom_range(1) == 1) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = last;
        while (!in_ready && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) begin
            check("accept_timeout", int'(in_ready), 1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_push(b, last);
    endtask

    task automatic send_frame(input int len, input bit gaps);
        for (int i = 0; i < len; i++)
            send_bit(1'($urandom_range(1)), i == len - 1, gaps);
    endtask

    task automatic drain();
        int n = 0;
        ordy_pct = 100;
        while ((exp_q.size() != 0 || busy || out_valid) && n < 3000) begin
            tick();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        check("busy_idle", int'(busy), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready",  int'(in_ready),  0);
        check("rst_wr_en",     int'(wr_en),     0);
        check("rst_wr_pad",    int'(wr_pad),    0);
        check("rst_wr_addr",   int'(wr_addr),   0);
        check("rst_wr_bank",   int'(wr_bank),   0);
        check("rst_rd_addr",   int'(rd_addr),   0);
        check("rst_rd_bank",   int'(rd_bank),   0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last",  int'(out_last),  0);
        check("rst_busy",      int'(busy),      0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: sampled mid-cycle, so it sees the handshakes the next edge commits.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (in_valid && in_ready) begin
                acc_cnt++;
                if (first_acc < 0) first_acc = cyc;
            end
            if (!wr_pad) check("wr_en_vs_accept", int'(wr_en), int'(in_valid & in_ready));
            if (wr_en) begin
                check("wr_addr", int'(wr_addr), w_pos);
                check("wr_bank", int'(wr_bank), w_bank);
                check("wr_pad",  int'(wr_pad),  int'(pad_exp));
                if (wr_pad) begin
                    pad_cnt++;
                    check("busy_pad", int'(busy), 1);
                    check("in_ready_pad", int'(in_ready), 0);
                end
                mem[wr_bank][wr_addr] = wr_pad ? 1'b0 : in_bit;
                if (!pad_exp && in_last && w_pos != N - 1) pad_exp = 1'b1;
                if (w_pos == N - 1) begin
                    w_pos = 0; w_bank ^= 1; pad_exp = 1'b0;
                end else begin
                    w_pos++;
                end
            end
            if (out_valid) begin
                ov_cnt++;
                if (first_ov < 0) first_ov = cyc;
                last_ov = cyc;
            end
            if (out_valid && out_ready) begin
                check("rd_bank", int'(rd_bank), r_bank);
                check("rd_addr", int'(rd_addr), perm_tab[r_pos]);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got bit at rd_addr %0d expected none (cycle %0d)", rd_addr, cyc);
                end else begin
                    obit_t e;
                    e = exp_q.pop_front();
                    check("out_bit",  int'(mem[rd_bank][rd_addr]), int'(e.b));
                    check("out_last", int'(out_last), int'(e.last));
                end
                out_cnt++;
                if (out_last) last_cnt++;
                if (r_pos == N - 1) begin
                    r_pos = 0; r_bank ^= 1;
                end else begin
                    r_pos++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   exp_total;
        int   nfr;
        int   idx;

        idx = 0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) begin
                perm_tab[idx] = r * COLS + c;
                idx++;
            end

        vecs[0] = '{6,  1'b0, 100, 10, 16};
        vecs[1] = '{16, 1'b0, 100, 0,  16};
        vecs[2] = '{1,  1'b0, 100, 15, 16};
        vecs[3] = '{20, 1'b1, 60,  12, 32};
        vecs[4] = '{32, 1'b0, 100, 0,  32};
        vecs[5] = '{47, 1'b1, 50,  1,  48};

        // Power-on reset
        model_clear();
        clear_stats();
        #1 rst = 1'b0;
        #2;
        check_reset_outputs();
        repeat (3) tick();
        rst    = 1'b1;
        mon_en = 1'b1;

        // Continuous 32 bits, downstream always ready
        clear_stats();
        ordy_pct  = 100;
        out_ready = 1'b1;
        send_frame(32, 1'b0);
        drain();
        check("first_valid_latency", first_ov - first_acc, 16);
        check("valid_cycles", ov_cnt, 32);
        check("valid_span", last_ov - first_ov, 31);
        check("outs_32", out_cnt, 32);

        // Table of frame lengths: padding, output count, single out_last
        foreach (vecs[i]) begin
            clear_stats();
            ordy_pct = vecs[i].pct;
            send_frame(vecs[i].len, vecs[i].gaps);
            drain();
            check($sformatf("vec%0d_pad", i),  pad_cnt,  vecs[i].exp_pad);
            check($sformatf("vec%0d_outs", i), out_cnt,  vecs[i].exp_outs);
            check($sformatf("vec%0d_last", i), last_cnt, 1);
        end

        // Downstream stall for 40 cycles: both banks fill, then backpressure
        clear_stats();
        ordy_pct   = 100;
        stall_left = 40;
        out_ready  = 1'b0;
        for (int i = 0; i < 32; i++) send_bit(1'($urandom_range(1)), 1'b0, 1'b0);
        check("stall_in_ready", int'(in_ready), 0);
        check("stall_accepts", acc_cnt, 32);
        check("stall_outs", out_cnt, 0);
        check("stall_out_valid", int'(out_valid), 1);
        repeat (3) tick();
        check("stall_in_ready_hold", int'(in_ready), 0);
        for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(1)), i == 15, 1'b0);
        drain();
        check("stall_total_outs", out_cnt, 48);
        check("stall_last", last_cnt, 1);

        // Reset in the middle of draining with the other bank half filled
        clear_stats();
        ordy_pct  = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 24; i++) send_bit(1'($urandom_range(1)), 1'b0, 1'b0);
        ordy_pct  = 100;
        out_ready = 1'b1;
        repeat (7) tick();
        check("pre_reset_outs", out_cnt, 7);
        mon_en = 1'b0;
        #3 rst = 1'b0;
        #1;
        check_reset_outputs();
        tick();
        tick();
        rst = 1'b1;
        model_clear();
        clear_stats();
        mon_en = 1'b1;
        for (int i = 0; i < 15; i++) send_bit(1'($urandom_range(1)), 1'b0, 1'b0);
        check("post_reset_no_valid", int'(out_valid), 0);
        send_bit(1'($urandom_range(1)), 1'b0, 1'b0);
        check("post_reset_valid", int'(out_valid), 1);
        check("post_reset_accepts", acc_cnt, 16);
        drain();
        check("post_reset_outs", out_cnt, 16);

        // Random frames with input gaps and random downstream readiness
        clear_stats();
        exp_total = 0;
        nfr = 8;
        for (int f = 0; f < nfr; f++) begin
            int len;
            len = int'($urandom_range(1, 40));
            exp_total += ((len + N - 1) / N) * N;
            ordy_pct = int'($urandom_range(40, 100));
            send_frame(len, 1'b1);
        end
        drain();
        check("rand_outs", out_cnt, exp_total);
        check("rand_lasts", last_cnt, nfr);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
